// File: rtl/vblank_update_scheduler_if.sv
// Handshake bundle between the VGA timing generator / game logic (master)
// and the vblank update scheduler (slave).
`timescale 1ns/1ps
interface vblank_update_scheduler_if #(
  parameter int DIV_W  = 6,
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
);
  logic              vblnk;
  logic              enable;
  logic              pause;
  logic [DIV_W-1:0]  frame_div;
  logic              upd_ack;
  logic              clr_ovr;
  logic              upd_req;
  logic              frame_tick;
  logic              swap;
  logic              overrun;
  logic              busy;
  logic [CNT_W-1:0]  tick_count;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output vblnk, enable, pause, frame_div, upd_ack, clr_ovr,
    input  upd_req, frame_tick, swap, overrun, busy, tick_count, drop_cnt
  );

  modport slave (
    input  vblnk, enable, pause, frame_div, upd_ack, clr_ovr,
    output upd_req, frame_tick, swap, overrun, busy, tick_count, drop_cnt
  );
endinterface

// File: rtl/vblank_update_scheduler.sv
// Paces game-state updates to the display frame: every N frames, at vblank
// start, request an update, then commit it with a swap pulse inside blanking.
`timescale 1ns/1ps
module vblank_update_scheduler #(
  parameter int DIV_W  = 6,
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input logic                      pclk,
  input logic                      rst_n,
  vblank_update_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_WAIT_VBL    = 2'd0,
    S_REQ         = 2'd1,
    S_COMMIT_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              vblnk_q;
  logic              upd_req_q, upd_req_d;
  logic              frame_tick_q, frame_tick_d;
  logic              swap_q, swap_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  tick_count_q, tick_count_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              rise;
  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  div_last;

  assign rise     = bus.vblnk & ~vblnk_q;
  assign div_eff  = (bus.frame_div == '0) ? DIV_W'(1) : bus.frame_div;
  assign div_last = div_eff - DIV_W'(1);

  // NOTE: every variable gets its hold/default value before the case so no
  // path leaves it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    upd_req_d    = upd_req_q;
    swap_d       = 1'b0;
    overrun_d    = overrun_q;
    tick_count_d = tick_count_q;
    drop_cnt_d   = drop_cnt_q;
    frame_tick_d = rise;

    // Clear first so a late completion on the same edge overrides it.
    if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      S_WAIT_VBL: begin
        if (rise && bus.enable && !bus.pause) begin
          // ">=" keeps a lowered frame_div from stranding the count.
          if (frame_cnt_q >= div_last) begin
            frame_cnt_d  = '0;
            upd_req_d    = 1'b1;
            tick_count_d = tick_count_q + CNT_W'(1);
            state_d      = S_REQ;
          end else begin
            frame_cnt_d = frame_cnt_q + DIV_W'(1);
          end
        end
      end

      S_REQ: begin
        if (bus.upd_ack) begin
          upd_req_d = 1'b0;
          if (bus.vblnk) begin
            swap_d  = 1'b1;
            state_d = S_WAIT_VBL;
          end else begin
            overrun_d = 1'b1;
            state_d   = S_COMMIT_WAIT;
          end
        end else if (rise && (drop_cnt_q != '1)) begin
          drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
      end

      S_COMMIT_WAIT: begin
        // The frame that carries the deferred commit never issues a request.
        if (rise) begin
          swap_d      = 1'b1;
          frame_cnt_d = '0;
          state_d     = S_WAIT_VBL;
        end
      end

      default: begin
        upd_req_d = 1'b0;
        state_d   = S_WAIT_VBL;
      end
    endcase

    busy_d = (state_d == S_REQ) || (state_d == S_COMMIT_WAIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT_VBL;
      frame_cnt_q  <= '0;
      vblnk_q      <= 1'b0;
      upd_req_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      swap_q       <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      tick_count_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      vblnk_q      <= bus.vblnk;
      upd_req_q    <= upd_req_d;
      frame_tick_q <= frame_tick_d;
      swap_q       <= swap_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      tick_count_q <= tick_count_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.upd_req    = upd_req_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.swap       = swap_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;
  assign bus.tick_count = tick_count_q;
  assign bus.drop_cnt   = drop_cnt_q;

  // A commit and an outstanding request are mutually exclusive by design.
  a_swap_excl_req: assert property (
    @(posedge pclk) disable iff (!rst_n) !(swap_q && upd_req_q)
  );

  a_req_implies_busy: assert property (
    @(posedge pclk) disable iff (!rst_n) upd_req_q |-> busy_q
  );

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Self-checking bench for vblank_update_scheduler: compressed frames, scenario
// tasks plus a randomized run, all compared against a frame-level model.
`timescale 1ns/1ps
module tb_vblank_update_scheduler;

  localparam int DIV_W     = 6;
  localparam int CNT_W     = 16;
  localparam int DROP_W    = 8;
  localparam int DROP_MAX  = (1 << DROP_W) - 1;
  localparam int VW        = 5 + CNT_W + DROP_W;
  // Shortened frame: 48 pixel clocks per frame, the last 16 in vertical blank.
  localparam int FRAME_LEN = 48;
  localparam int VBL_LEN   = 16;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  vblank_update_scheduler_if #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DROP_W(DROP_W)) bus ();

  vblank_update_scheduler #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DROP_W(DROP_W)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int pos       = 0;
  int ack_delay = -1;
  int req_age   = 0;
  bit spurious  = 1'b0;

  // Reference model: an update is either outstanding, finished late and
  // waiting for the next blanking start, or neither.
  bit m_prev, m_pending, m_late, m_tick, m_swap, m_ovr;
  int m_frames, m_issued, m_dropped;
  wire m_rise = bus.vblnk & ~m_prev;

  function automatic int div_of(logic [DIV_W-1:0] d);
    return (d == '0) ? 1 : int'(d);
  endfunction

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= 0; m_pending <= 0; m_late <= 0; m_tick <= 0; m_swap <= 0; m_ovr <= 0;
      m_frames <= 0; m_issued <= 0; m_dropped <= 0;
    end else begin
      m_prev <= bus.vblnk;
      m_tick <= m_rise;
      m_swap <= 0;
      if (bus.clr_ovr) m_ovr <= 0;
      if (m_pending) begin
        if (bus.upd_ack) begin
          m_pending <= 0;
          if (bus.vblnk) m_swap <= 1;
          else begin m_late <= 1; m_ovr <= 1; end
        end else if (m_rise) begin
          m_dropped <= m_dropped + 1;
        end
      end else if (m_late) begin
        if (m_rise) begin m_late <= 0; m_swap <= 1; m_frames <= 0; end
      end else if (m_rise && bus.enable && !bus.pause) begin
        if (m_frames + 1 >= div_of(bus.frame_div)) begin
          m_frames <= 0; m_pending <= 1; m_issued <= m_issued + 1;
        end else begin
          m_frames <= m_frames + 1;
        end
      end
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    return {m_pending, m_tick, m_swap, m_ovr, m_pending | m_late, CNT_W'(m_issued),
            DROP_W'((m_dropped > DROP_MAX) ? DROP_MAX : m_dropped)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.upd_req, bus.frame_tick, bus.swap, bus.overrun, bus.busy,
            bus.tick_count, bus.drop_cnt};
  endfunction

  // Advance the frame position and let the game-logic responder react.
  task automatic drive_next();
    pos = (pos + 1) % FRAME_LEN;
    bus.vblnk   = (pos >= FRAME_LEN - VBL_LEN);
    bus.clr_ovr = 1'b0;
    if (bus.upd_req) begin
      bus.upd_ack = (req_age == ack_delay);
      req_age++;
    end else begin
      req_age = 0;
      bus.upd_ack = spurious && ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.enable = 1'b1; bus.pause = 1'b0; bus.frame_div = DIV_W'(1);
    bus.upd_ack = 1'b0; bus.clr_ovr = 1'b0; bus.vblnk = 1'b0;
    pos = 0; req_age = 0; ack_delay = -1; spurious = 1'b0;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge pclk);
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), {VW{1'b0}});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_idle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      drive_next();
    end
  endtask

  task automatic test_div1();
    int ticks = 0, swaps = 0, coinc = 0;
    do_reset();
    ack_delay = 10;
    for (int c = 0; c < 150; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL div1_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (bus.frame_tick) begin ticks++; if (bus.upd_req) coinc++; end
      if (bus.swap) swaps++;
      drive_next();
    end
    checks++; if (ticks != 3) begin errors++; $display("FAIL div1_ticks got=%0d exp=3", ticks); end
    checks++; if (coinc != 3) begin errors++; $display("FAIL div1_req_with_tick got=%0d exp=3", coinc); end
    checks++; if (swaps != 3) begin errors++; $display("FAIL div1_swaps got=%0d exp=3", swaps); end
    checks++; if (bus.tick_count !== CNT_W'(3)) begin
      errors++; $display("FAIL div1_tick_count got=%0d exp=3", bus.tick_count); end
    checks++; if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL div1_overrun got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_div3();
    int ticks = 0, swaps = 0, nreq = 0;
    int req_frame [3];
    logic prev_req = 1'b0;
    do_reset();
    bus.frame_div = DIV_W'(3);
    ack_delay = 0;
    for (int c = 0; c < 420; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL div3_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (bus.frame_tick) ticks++;
      if (bus.swap) swaps++;
      if (bus.upd_req && !prev_req) begin
        if (nreq < 3) req_frame[nreq] = ticks;
        nreq++;
      end
      prev_req = bus.upd_req;
      drive_next();
    end
    checks++; if (ticks != 9) begin errors++; $display("FAIL div3_ticks got=%0d exp=9", ticks); end
    checks++; if (nreq != 3) begin errors++; $display("FAIL div3_requests got=%0d exp=3", nreq); end
    checks++; if (swaps != 3) begin errors++; $display("FAIL div3_swaps got=%0d exp=3", swaps); end
    for (int i = 0; i < 3 && i < nreq; i++) begin
      checks++;
      if (req_frame[i] != 3 * (i + 1)) begin
        errors++; $display("FAIL div3_req_frame idx=%0d got=%0d exp=%0d", i, req_frame[i], 3 * (i + 1));
      end
    end
  endtask

  task automatic test_overrun();
    int ticks = 0, swaps = 0;
    bit ovr_seen = 0;
    do_reset();
    ack_delay = VBL_LEN + 4;
    for (int c = 0; c < 135; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL ovr_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (bus.swap) swaps++;
      if (bus.overrun && !ovr_seen) begin
        ovr_seen = 1;
        checks++; if (swaps != 0 || bus.swap !== 1'b0) begin
          errors++; $display("FAIL ovr_no_swap_at_ack got=%0d exp=0", swaps); end
      end
      if (bus.frame_tick) begin
        ticks++;
        if (ticks == 2) begin
          checks++; if (bus.swap !== 1'b1 || bus.upd_req !== 1'b0) begin
            errors++; $display("FAIL ovr_commit swap=%b req=%b exp swap=1 req=0", bus.swap, bus.upd_req); end
        end
        if (ticks == 3) begin
          checks++; if (bus.upd_req !== 1'b1) begin
            errors++; $display("FAIL ovr_next_req got=%b exp=1", bus.upd_req); end
        end
      end
      drive_next();
    end
    checks++; if (bus.overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
    checks++; if (swaps != 1) begin errors++; $display("FAIL ovr_swaps got=%0d exp=1", swaps); end
    ack_delay = -1;
    bus.clr_ovr = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL ovr_clear_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      drive_next();
    end
    checks++; if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_cleared got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_drop_saturate();
    int ticks = 0, req_low = 0;
    do_reset();
    for (int c = 0; c < 300 * FRAME_LEN - 10; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL drop_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (bus.frame_tick) ticks++;
      if (ticks > 0 && !bus.upd_req) req_low++;
      drive_next();
    end
    checks++; if (ticks != 300) begin errors++; $display("FAIL drop_ticks got=%0d exp=300", ticks); end
    checks++; if (req_low != 0) begin errors++; $display("FAIL drop_req_held low_cycles=%0d exp=0", req_low); end
    checks++; if (bus.drop_cnt !== DROP_W'(DROP_MAX)) begin
      errors++; $display("FAIL drop_saturated got=%0d exp=%0d", bus.drop_cnt, DROP_MAX); end
    checks++; if (bus.tick_count !== CNT_W'(1)) begin
      errors++; $display("FAIL drop_tick_count got=%0d exp=1", bus.tick_count); end
  endtask

  task automatic test_pause();
    int ticks = 0, paused_reqs = 0, first_req = -1;
    do_reset();
    bus.frame_div = DIV_W'(2);
    bus.pause = 1'b1;
    ack_delay = 0;
    for (int c = 0; c < 280; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL pause_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (bus.frame_tick) ticks++;
      if (bus.upd_req && bus.pause) paused_reqs++;
      if (bus.upd_req && first_req < 0) first_req = ticks;
      drive_next();
      if (bus.frame_tick && ticks == 4) bus.pause = 1'b0;
    end
    checks++; if (paused_reqs != 0) begin errors++; $display("FAIL pause_no_req got=%0d exp=0", paused_reqs); end
    checks++; if (ticks != 6) begin errors++; $display("FAIL pause_ticks got=%0d exp=6", ticks); end
    checks++; if (first_req != 6) begin
      errors++; $display("FAIL pause_resume_frame got=%0d exp=6", first_req); end
  endtask

  task automatic test_reset_mid_req();
    int swaps = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst_pre t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      drive_next();
    end
    checks++; if (bus.upd_req !== 1'b1) begin
      errors++; $display("FAIL midrst_in_req got=%b exp=1", bus.upd_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.upd_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_async req=%b busy=%b exp 0 0", bus.upd_req, bus.busy); end
    checks++; if (bus.tick_count !== '0 || bus.swap !== 1'b0) begin
      errors++; $display("FAIL midrst_counts tick_count=%0d swap=%b exp 0 0", bus.tick_count, bus.swap); end
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst_post t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (bus.swap) swaps++;
      drive_next();
      if (c == 2) rst_n = 1'b1;
    end
    checks++; if (swaps != 0) begin errors++; $display("FAIL midrst_no_swap got=%0d exp=0", swaps); end
  endtask

  task automatic test_random();
    do_reset();
    spurious = 1'b1;
    ack_delay = 5;
    for (int c = 0; c < 6000; c++) begin
      @(negedge pclk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      drive_next();
      if (bus.frame_tick) begin
        bus.enable    = ($urandom_range(0, 7) != 0);
        bus.pause     = ($urandom_range(0, 7) == 0);
        bus.frame_div = DIV_W'($urandom_range(0, 3));
        ack_delay     = int'($urandom_range(0, 60));
      end
      if ($urandom_range(0, 31) == 0) bus.clr_ovr = 1'b1;
    end
  endtask

  initial begin
    bus.vblnk = 1'b0; bus.enable = 1'b0; bus.pause = 1'b0; bus.frame_div = '0;
    bus.upd_ack = 1'b0; bus.clr_ovr = 1'b0;
    test_reset();
    test_div1();
    test_div3();
    test_overrun();
    test_drop_saturate();
    test_pause();
    test_reset_mid_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Paces game-state updates (snake move, food placement) to the 800x600@60 display frame, using the blanking flag from the VGA timing generator.
- Every N frames, at the start of vertical blank, it raises a request to the game logic and waits for an acknowledge.
- It emits a buffer-swap pulse only when the update has completed, and records updates that overran the blanking window.
- Sits between the VGA timing generator and the game/draw logic in the pclk domain.

Parameters:
- DIV_W, 6, width of the frame-divider input.
- CNT_W, 16, width of the issued-update counter.
- DROP_W, 8, width of the saturating dropped-frame counter.

Ports:
- pclk  input  1  pixel clock (40 MHz).
- rst_n  input  1  asynchronous active-low reset.
- vblnk  input  1  vertical blank flag from the timing generator; high for vcount 600..627.
- enable  input  1  permits new update ticks.
- pause  input  1  freezes the frame divider and suppresses requests; frame_tick still runs.
- frame_div  input  DIV_W  frames per update; 0 is treated as 1.
- upd_ack  input  1  game logic has finished the requested update.
- clr_ovr  input  1  one-cycle pulse that clears overrun.
- upd_req  output  1  update request; level, held until acknowledged.
- frame_tick  output  1  one-cycle pulse at each vblank start.
- swap  output  1  one-cycle pulse to commit the back buffer.
- overrun  output  1  sticky; set when an update finished outside vblank.
- busy  output  1  high in the REQ or COMMIT_WAIT state.
- tick_count  output  CNT_W  number of requests issued; wraps.
- drop_cnt  output  DROP_W  vblank starts seen while in REQ; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0, including every counter.
  - State is WAIT_VBL, frame_cnt is 0, vblnk_q is 0.
  - Assertion mid-handshake aborts immediately: upd_req drops with no swap.
- All outputs are registered.
- Edge detection: vblnk is sampled every edge into vblnk_q. rise = vblnk & ~vblnk_q, evaluated at the edge.
- frame_tick is 1 for exactly the cycle following the first edge that samples vblnk=1. Latency is 1 edge. It is independent of state, enable and pause.
- div_eff = (frame_div == 0) ? 1 : frame_div. frame_div is read live.
- State WAIT_VBL, on rise:
  - enable=1 and pause=0:
    - If frame_cnt >= div_eff-1: frame_cnt←0, upd_req←1, tick_count++, go to REQ. The ">=" handles frame_div being lowered mid-count.
    - Else: frame_cnt++.
  - enable=0 or pause=1: frame_cnt holds, no request.
- State REQ:
  - upd_req stays 1 until an edge samples upd_ack=1. At that edge upd_req←0.
  - If vblnk=1 at that edge: swap←1 for one cycle, go to WAIT_VBL.
  - If vblnk=0 at that edge: overrun←1, go to COMMIT_WAIT.
  - A rise while still in REQ: drop_cnt++ (saturating), no new request, frame_cnt unchanged.
  - Deasserting enable or asserting pause in REQ does not withdraw upd_req.
  - Ack and rise on the same edge: the ack path wins; drop_cnt is not incremented.
- State COMMIT_WAIT: on the next rise, swap←1, frame_cnt←0, go to WAIT_VBL. That frame is not a tick candidate.
- upd_ack is ignored in WAIT_VBL and COMMIT_WAIT.
- overrun:
  - Cleared by clr_ovr.
  - Set and clr_ovr on the same edge: set wins.
- busy = (state == REQ) | (state == COMMIT_WAIT), registered with the state.
- swap and upd_req are never both 1 in the same cycle.

Test Plan:
- Reset then free-run, frame_div=1, ack 10 cycles after req -> upd_req rises with the first frame_tick and falls at the ack edge; swap pulses once per frame; tick_count=3 after 3 frames; overrun=0.
- frame_div=3, immediate ack, 9 frames -> exactly 3 requests, on frames 3, 6 and 9; frame_tick pulses 9 times.
- Ack delivered 30000 cycles after req, i.e. after vblnk falls (vblank lasts 28×1056=29568 cycles) -> overrun=1; no swap at the ack; swap at the next vblank start; next request 1 frame later with div=1; clr_ovr then gives overrun=0.
- Req held with no ack across 300 frames -> drop_cnt saturates at 255; upd_req stays 1 throughout; tick_count stays 1.
- pause=1 for 4 frames with frame_div=2 -> no requests and frame_cnt frozen; frame_tick still pulses 4 times; the request resumes on the 2nd frame after pause drops.
- rst_n pulsed low mid-REQ (asynchronously, between edges) -> upd_req, busy and tick_count read 0 immediately, before the next edge; no swap is emitted.
